// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - func3 codes of the M-extension operations and the funct7 that marks them
//   - FSM state encoding
//   - helpers telling which operands are treated as signed
package muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_DONE = 2'd2
    } mds_state_t;

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic op1_is_signed(input logic [2:0] func3);
        return (func3 == MD_MUL) || (func3 == MD_MULH) || (func3 == MD_MULHSU) ||
               (func3 == MD_DIV) || (func3 == MD_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM (MULHSU keeps rs2 unsigned)
    function automatic logic op2_is_signed(input logic [2:0] func3);
        return (func3 == MD_MUL) || (func3 == MD_MULH) ||
               (func3 == MD_DIV) || (func3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath: shift-add multiplier and restoring divider
// sharing one accumulator pair, plus the iteration counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture load_a / load_b, clear accumulator and counter
//   step              perform one iteration
//   is_div            1: divide iteration, 0: multiply iteration
//   load_a, load_b    unsigned magnitudes (multiplier/dividend, multiplicand/divisor)
//   last              current step is the final one (counter == XLEN-1)
//   product, quotient, remainder
//                     values the accumulator holds after the current step, so
//                     the caller can register the final result on the same
//                     edge that performs the last iteration
module muldiv_iter_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [XLEN-1:0]     load_a,
    input  logic [XLEN-1:0]     load_b,
    output logic                last,
    output logic [2*XLEN-1:0]   product,
    output logic [XLEN-1:0]     quotient,
    output logic [XLEN-1:0]     remainder
);

    // hi_reg: product high half / partial remainder (one guard bit for the trial subtract)
    // lo_reg: multiplier bits being consumed / dividend bits shifting out, quotient shifting in
    logic [XLEN:0]      hi_reg, hi_next;
    logic [XLEN-1:0]    lo_reg, lo_next;
    logic [XLEN-1:0]    b_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [XLEN-1:0]    addend;
    logic [XLEN:0]      sum;
    logic [XLEN:0]      shifted;
    logic [XLEN:0]      trial;

    // Multiplicand gated by the current multiplier bit
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
        assign addend[gi] = b_reg[gi] & lo_reg[0];
    end

    always_comb begin
        sum     = {1'b0, hi_reg[XLEN-1:0]} + {1'b0, addend};
        shifted = {hi_reg[XLEN-1:0], lo_reg[XLEN-1]};
        trial   = shifted - {1'b0, b_reg};
        if (is_div) begin
            // Negative trial restores the shifted remainder and shifts in a 0
            hi_next = trial[XLEN] ? shifted : trial;
            lo_next = {lo_reg[XLEN-2:0], ~trial[XLEN]};
        end else begin
            hi_next = {1'b0, sum[XLEN:1]};
            lo_next = {sum[0], lo_reg[XLEN-1:1]};
        end
    end

    assign product   = {hi_next[XLEN-1:0], lo_next};
    assign quotient  = lo_next;
    assign remainder = hi_next[XLEN-1:0];
    assign last      = (cnt_reg == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            b_reg   <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            hi_reg  <= '0;
            lo_reg  <= load_a;
            b_reg   <= load_b;
            cnt_reg <= '0;
        end else if (step) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the Execute stage.
// Accepts one M-extension op, runs it over XLEN cycles in muldiv_iter_core,
// stalls the pipeline meanwhile and pulses o_done with the result.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      M-extension op present in EX (sampled in IDLE only)
//   i_func3      operation select (MUL..REMU)
//   i_op1/i_op2  forwarded rs1/rs2
//   i_kill       flush; aborts the op in flight, blocks a start
//   o_busy       state is not IDLE
//   o_stall      freeze IF/ID/EX
//   o_done       one-cycle result-valid pulse
//   o_result     result, valid while o_done=1 (0 otherwise)
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    mds_state_t         state_reg;
    logic [2:0]         func3_reg;
    logic               sign1_reg;
    logic               sign2_reg;
    logic [XLEN-1:0]    result_reg;

    // Acceptance-side decode
    logic               accept;
    logic               sign1, sign2;
    logic [XLEN-1:0]    mag1, mag2;
    logic               div_zero, div_ovf, special;
    logic [XLEN-1:0]    special_res;

    // Core interface
    logic               core_last;
    logic [2*XLEN-1:0]  core_prod;
    logic [XLEN-1:0]    core_quo, core_rem;

    // Sign fix-up of the final iteration's values
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix, final_res;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        accept   = (state_reg == MDS_IDLE) && i_start && !i_kill;
        sign1    = op1_is_signed(i_func3) & i_op1[XLEN-1];
        sign2    = op2_is_signed(i_func3) & i_op2[XLEN-1];
        mag1     = sign1 ? -i_op1 : i_op1;
        mag2     = sign2 ? -i_op2 : i_op2;
        div_zero = (i_op2 == '0);
        div_ovf  = ((i_func3 == MD_DIV) || (i_func3 == MD_REM)) &&
                   (i_op1 == INT_MIN) && (i_op2 == '1);
        special  = i_func3[2] && (div_zero || div_ovf);
        // func3[1] selects the remainder variants
        if (div_zero) begin
            special_res = i_func3[1] ? i_op1 : '1;
        end else begin
            special_res = i_func3[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        // Sign flags of unsigned operands are already zero, so one XOR covers
        // MUL/MULH/MULHSU/MULHU alike
        prod_fix = (sign1_reg ^ sign2_reg) ? -core_prod : core_prod;
        quo_fix  = (sign1_reg ^ sign2_reg) ? -core_quo  : core_quo;
        rem_fix  = sign1_reg ? -core_rem : core_rem;
        case (func3_reg)
            MD_MUL:                final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU,
            MD_MULHU:              final_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:       final_res = quo_fix;
            default:               final_res = rem_fix;
        endcase
    end

    muldiv_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && !special),
        .step      (state_reg == MDS_CALC),
        .is_div    (func3_reg[2]),
        .load_a    (mag1),
        .load_b    (mag2),
        .last      (core_last),
        .product   (core_prod),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= MDS_IDLE;
            func3_reg  <= '0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                MDS_IDLE: begin
                    if (accept) begin
                        func3_reg <= i_func3;
                        sign1_reg <= sign1;
                        sign2_reg <= sign2;
                        if (special) begin
                            result_reg <= special_res;
                            state_reg  <= MDS_DONE;
                        end else begin
                            state_reg  <= MDS_CALC;
                        end
                    end
                end
                MDS_CALC: begin
                    if (i_kill) begin
                        state_reg <= MDS_IDLE;
                    end else if (core_last) begin
                        result_reg <= final_res;
                        state_reg  <= MDS_DONE;
                    end
                end
                default: begin
                    state_reg <= MDS_IDLE;
                end
            endcase
        end
    end

    // Start is ignored while reset is asserted, hence the rst_n term
    assign o_busy   = (state_reg != MDS_IDLE);
    assign o_stall  = rst_n && (accept || (state_reg == MDS_CALC));
    assign o_done   = (state_reg == MDS_DONE) && !i_kill;
    assign o_result = o_done ? result_reg : '0;

endmodule
